alu_ctrl_seq: RTL

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU control decoder with valid/ready handshake and multi-cycle MUL sequencing
module alu_ctrl_seq #(
    parameter int CTRL_W    = 3,
    parameter int OP_W      = 2,
    parameter int FUNCT_W   = 3,
    parameter int MC_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic               illegal,
    output logic               busy
);

    localparam int CNT_W = ($clog2(MC_CYCLES) < 1) ? 1 : $clog2(MC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 2);

    localparam logic [CTRL_W-1:0] C_NOP = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] C_MUL = CTRL_W'(5);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_WAIT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic              illegal_q;

    logic [CTRL_W-1:0] dec_code;
    logic              dec_illegal;
    logic              dec_mul;
    logic              in_xfer;

    // Decode the incoming request; compares are done at 32 bits so odd field widths stay correct
    always_comb begin
        dec_code    = C_NOP;
        dec_illegal = 1'b0;
        if (32'(alu_op) == 32'd0) begin
            if (32'(funct) == 32'd0 || 32'(funct) > 32'd5) begin
                dec_code    = C_NOP;
                dec_illegal = 1'b1;
            end else begin
                dec_code    = CTRL_W'(funct);
            end
        end else if (32'(alu_op) == 32'd1) begin
            dec_code = C_ADD;
        end else if (32'(alu_op) == 32'd2) begin
            dec_code = C_SUB;
        end else if (32'(alu_op) == 32'd3) begin
            dec_code = C_AND;
        end else begin
            dec_code    = C_NOP;
            dec_illegal = 1'b1;
        end
        dec_mul = !dec_illegal && (dec_code == C_MUL);
    end

    // Next-state, counter and handshake outputs
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        in_xfer   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                in_xfer  = in_valid;
                if (in_xfer) begin
                    if (dec_mul) begin
                        state_d = MC_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            MC_WAIT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                in_xfer   = in_valid && out_ready;
                if (out_ready) begin
                    if (in_xfer) begin
                        if (dec_mul) begin
                            state_d = MC_WAIT;
                            cnt_d   = CNT_LOAD;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and captured result registers; result is loaded only on an input transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (in_xfer) begin
                ctrl_q    <= dec_code;
                illegal_q <= dec_illegal;
            end
        end
    end

    assign ctrl_out = ctrl_q;
    assign illegal  = illegal_q && (state == HOLD);

endmodule
